rename_regfile: RTL and testbench

- Parametrised architectural register file with rename-tag (ROB nick) tracking, placed between the instruction decoder and the dispatch stage.
- Supplies rs1/rs2 values or pending tags through a registered, back-pressured dispatch output.
- Accepts one rename and one commit per cycle, and forwards same-cycle rename and commit information to operand reads.
- Clears all pending tags on a pipeline flush.

---
 rtl/rename_regfile_pkg.sv | 27 ++
 rtl/rename_regfile_operand_read.sv | 47 ++++
 rtl/rename_regfile.sv | 166 ++++++++++++++++
 tb/tb_rename_regfile.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_regfile_pkg.sv
// Shared widths, sentinel values and dispatch record types for the rename register file.
package rf_pkg;
  localparam int RF_XLEN  = 32;
  localparam int RF_NREG  = 32;
  localparam int RF_TAG_W = 4;
  localparam int RF_OP_W  = 6;
  localparam int RF_IMM_W = 32;
  localparam int RF_RW    = $clog2(RF_NREG);

  localparam int TAG_NONE = 0;
  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic [RF_XLEN-1:0]  dt;
    logic [RF_TAG_W-1:0] tag;
  } rf_operand_t;

  typedef struct packed {
    logic [RF_RW-1:0]    rd;
    logic [RF_OP_W-1:0]  op;
    logic [RF_XLEN-1:0]  pc;
    logic [RF_IMM_W-1:0] imm;
    logic                pd;
    rf_operand_t         rs1;
    rf_operand_t         rs2;
  } rf_payload_t;
endpackage

// File: rtl/rename_regfile_operand_read.sv
// One operand read port: x0 / same-cycle rename / same-cycle commit forwarding over the array.
// Commit forwarding exists only when RF_COMMIT_BYPASS_EN is defined.
module rf_operand_read
  import rf_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int TAG_W = RF_TAG_W,
  parameter int RW    = RF_RW
) (
  input  logic [RW-1:0]    i_rs,
  input  logic [XLEN-1:0]  i_arr_dt,
  input  logic [TAG_W-1:0] i_arr_tag,
  input  logic             i_rn_en,
  input  logic [RW-1:0]    i_rn_reg,
  input  logic [TAG_W-1:0] i_rn_tag,
  input  logic             i_cm_en,
  input  logic [RW-1:0]    i_cm_reg,
  input  logic [XLEN-1:0]  i_cm_dt,
  input  logic [TAG_W-1:0] i_cm_tag,
  output logic [XLEN-1:0]  o_dt,
  output logic [TAG_W-1:0] o_tag
);

  always_comb begin
    o_dt  = i_arr_dt;
    o_tag = i_arr_tag;
    if (i_rs == RW'(REG_ZERO)) begin
      o_dt  = '0;
      o_tag = TAG_W'(TAG_NONE);
    end else if (i_rn_en && (i_rn_reg == i_rs)) begin
      o_tag = i_rn_tag;
    end
`ifdef RF_COMMIT_BYPASS_EN
    else if (i_cm_en && (i_cm_reg == i_rs) && (i_arr_tag == i_cm_tag)) begin
      o_dt  = i_cm_dt;
      o_tag = TAG_W'(TAG_NONE);
    end
`endif
  end

`ifndef RF_COMMIT_BYPASS_EN
  // Without the bypass a same-cycle commit only reaches reads through the array.
  logic w_unused_cm;
  assign w_unused_cm = ^{i_cm_en, i_cm_reg, i_cm_dt, i_cm_tag};
`endif

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with rename-tag tracking and a registered dispatch stage.
// Optional RF_COMMIT_BYPASS_EN: forward same-cycle commits to reads and wake held operands.
module rename_regfile
  import rf_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREG  = RF_NREG,
  parameter int TAG_W = RF_TAG_W,
  parameter int OP_W  = RF_OP_W,
  parameter int IMM_W = RF_IMM_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [$clog2(NREG)-1:0]  in_rs1,
  input  logic [$clog2(NREG)-1:0]  in_rs2,
  input  logic [$clog2(NREG)-1:0]  in_rd,
  input  logic [OP_W-1:0]          in_op,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [IMM_W-1:0]         in_imm,
  input  logic                     in_pd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_rs1_dt,
  output logic [XLEN-1:0]          out_rs2_dt,
  output logic [TAG_W-1:0]         out_rs1_tag,
  output logic [TAG_W-1:0]         out_rs2_tag,
  output logic [$clog2(NREG)-1:0]  out_rd,
  output logic [OP_W-1:0]          out_op,
  output logic [XLEN-1:0]          out_pc,
  output logic [IMM_W-1:0]         out_imm,
  output logic                     out_pd,
  input  logic                     rn_en,
  input  logic [$clog2(NREG)-1:0]  rn_reg,
  input  logic [TAG_W-1:0]         rn_tag,
  input  logic                     cm_en,
  input  logic [$clog2(NREG)-1:0]  cm_reg,
  input  logic [XLEN-1:0]          cm_dt,
  input  logic [TAG_W-1:0]         cm_tag
);

  localparam int RW = $clog2(NREG);

  typedef struct packed {
    logic [XLEN-1:0]  dt;
    logic [TAG_W-1:0] tag;
  } opnd_t;

  typedef struct packed {
    logic [RW-1:0]    rd;
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  pc;
    logic [IMM_W-1:0] imm;
    logic             pd;
    opnd_t            rs1;
    opnd_t            rs2;
  } pay_t;

  logic [XLEN-1:0]  r_data [NREG];
  logic [TAG_W-1:0] r_tag  [NREG];
  logic             r_vld;
  pay_t             r_pay;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_cm_wr;
  logic             w_cm_clr;
  logic             w_rn_wr;
  logic             w_wk1;
  logic             w_wk2;
  opnd_t            w_rd1;
  opnd_t            w_rd2;

  assign w_in_ready = rdy && !clr && (!r_vld || out_ready);
  assign w_accept   = in_valid && w_in_ready;

  // Commit data lands even during a flush; rename always beats the commit's tag clear.
  assign w_cm_wr  = rdy && cm_en && (cm_reg != RW'(REG_ZERO));
  assign w_cm_clr = w_cm_wr && (r_tag[cm_reg] == cm_tag) && !(rn_en && (rn_reg == cm_reg));
  assign w_rn_wr  = rdy && !clr && rn_en && (rn_reg != RW'(REG_ZERO));

  rf_operand_read #(.XLEN(XLEN), .TAG_W(TAG_W), .RW(RW)) u_rd1 (
    .i_rs(in_rs1), .i_arr_dt(r_data[in_rs1]), .i_arr_tag(r_tag[in_rs1]),
    .i_rn_en(rn_en), .i_rn_reg(rn_reg), .i_rn_tag(rn_tag),
    .i_cm_en(cm_en), .i_cm_reg(cm_reg), .i_cm_dt(cm_dt), .i_cm_tag(cm_tag),
    .o_dt(w_rd1.dt), .o_tag(w_rd1.tag)
  );

  rf_operand_read #(.XLEN(XLEN), .TAG_W(TAG_W), .RW(RW)) u_rd2 (
    .i_rs(in_rs2), .i_arr_dt(r_data[in_rs2]), .i_arr_tag(r_tag[in_rs2]),
    .i_rn_en(rn_en), .i_rn_reg(rn_reg), .i_rn_tag(rn_tag),
    .i_cm_en(cm_en), .i_cm_reg(cm_reg), .i_cm_dt(cm_dt), .i_cm_tag(cm_tag),
    .o_dt(w_rd2.dt), .o_tag(w_rd2.tag)
  );

`ifdef RF_COMMIT_BYPASS_EN
  assign w_wk1 = cm_en && (cm_tag != TAG_W'(TAG_NONE)) && (r_pay.rs1.tag == cm_tag);
  assign w_wk2 = cm_en && (cm_tag != TAG_W'(TAG_NONE)) && (r_pay.rs2.tag == cm_tag);
`else
  assign w_wk1 = 1'b0;
  assign w_wk2 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= '0;
      end
    end else begin
      if (w_cm_wr) r_data[cm_reg] <= cm_dt;
      if (clr) begin
        for (int i = 0; i < NREG; i++) r_tag[i] <= '0;
      end else begin
        if (w_cm_clr) r_tag[cm_reg] <= '0;
        if (w_rn_wr)  r_tag[rn_reg] <= rn_tag;
      end
    end
  end

  // Dispatch stage: load on accept, drop valid on drain, otherwise hold (with optional wakeup).
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_vld <= 1'b0;
      r_pay <= '0;
    end else if (rdy) begin
      if (w_accept) begin
        r_vld     <= 1'b1;
        r_pay.rd  <= in_rd;
        r_pay.op  <= in_op;
        r_pay.pc  <= in_pc;
        r_pay.imm <= in_imm;
        r_pay.pd  <= in_pd;
        r_pay.rs1 <= w_rd1;
        r_pay.rs2 <= w_rd2;
      end else if (out_ready) begin
        r_vld <= 1'b0;
      end else if (r_vld) begin
        if (w_wk1) begin
          r_pay.rs1.dt  <= cm_dt;
          r_pay.rs1.tag <= '0;
        end
        if (w_wk2) begin
          r_pay.rs2.dt  <= cm_dt;
          r_pay.rs2.tag <= '0;
        end
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_vld;
  assign out_rs1_dt  = r_pay.rs1.dt;
  assign out_rs1_tag = r_pay.rs1.tag;
  assign out_rs2_dt  = r_pay.rs2.dt;
  assign out_rs2_tag = r_pay.rs2.tag;
  assign out_rd      = r_pay.rd;
  assign out_op      = r_pay.op;
  assign out_pc      = r_pay.pc;
  assign out_imm     = r_pay.imm;
  assign out_pd      = r_pay.pd;

endmodule

// File: tb/tb_rename_regfile.sv
// Self-checking bench for rename_regfile: directed scenarios plus randomized traffic against a reference model.
module tb_rename_regfile;
  import rf_pkg::*;

  localparam int XLEN = RF_XLEN, NREG = RF_NREG, TAG_W = RF_TAG_W;
  localparam int OP_W = RF_OP_W, IMM_W = RF_IMM_W, RW = RF_RW;
`ifdef RF_COMMIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rdy, clr, in_valid, in_ready, in_pd, out_valid, out_ready, out_pd;
  logic [RW-1:0] in_rs1, in_rs2, in_rd, out_rd, rn_reg, cm_reg;
  logic [OP_W-1:0] in_op, out_op;
  logic [XLEN-1:0] in_pc, out_pc, out_rs1_dt, out_rs2_dt, cm_dt;
  logic [IMM_W-1:0] in_imm, out_imm;
  logic [TAG_W-1:0] out_rs1_tag, out_rs2_tag, rn_tag, cm_tag;
  logic rn_en, cm_en;

  rename_regfile dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_op(in_op),
    .in_pc(in_pc), .in_imm(in_imm), .in_pd(in_pd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_dt(out_rs1_dt), .out_rs2_dt(out_rs2_dt),
    .out_rs1_tag(out_rs1_tag), .out_rs2_tag(out_rs2_tag),
    .out_rd(out_rd), .out_op(out_op), .out_pc(out_pc), .out_imm(out_imm), .out_pd(out_pd),
    .rn_en(rn_en), .rn_reg(rn_reg), .rn_tag(rn_tag),
    .cm_en(cm_en), .cm_reg(cm_reg), .cm_dt(cm_dt), .cm_tag(cm_tag)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural view of registers, tags and the dispatch slot.
  logic [XLEN-1:0]  m_data [NREG];
  logic [TAG_W-1:0] m_tag  [NREG];
  logic             m_vld;
  rf_payload_t      m_pay;

  function automatic rf_operand_t mread(input logic [RW-1:0] rs);
    rf_operand_t o;
    if (rs == 0)                                          o = '{dt: '0, tag: '0};
    else if (rn_en && rn_reg == rs)                       o = '{dt: m_data[rs], tag: rn_tag};
    else if (BYP && cm_en && cm_reg == rs && m_tag[rs] == cm_tag) o = '{dt: cm_dt, tag: '0};
    else                                                  o = '{dt: m_data[rs], tag: m_tag[rs]};
    return o;
  endfunction

  function automatic logic m_ready();
    return rdy && !clr && (!m_vld || out_ready);
  endfunction

  function automatic rf_payload_t dut_pay();
    return '{rd: out_rd, op: out_op, pc: out_pc, imm: out_imm, pd: out_pd,
             rs1: '{dt: out_rs1_dt, tag: out_rs1_tag}, rs2: '{dt: out_rs2_dt, tag: out_rs2_tag}};
  endfunction

  task automatic model_step();
    rf_operand_t o1, o2;
    logic acc;
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin m_data[i] = '0; m_tag[i] = '0; end
      m_vld = 1'b0;
      m_pay = '0;
      return;
    end
    acc = in_valid && m_ready();
    o1  = mread(in_rs1);
    o2  = mread(in_rs2);
    if (rdy && cm_en && cm_reg != 0) begin
      if (m_tag[cm_reg] == cm_tag && !(rn_en && rn_reg == cm_reg)) m_tag[cm_reg] = '0;
      m_data[cm_reg] = cm_dt;
    end
    if (rdy && !clr && rn_en && rn_reg != 0) m_tag[rn_reg] = rn_tag;
    if (clr) for (int i = 0; i < NREG; i++) m_tag[i] = '0;
    if (clr) begin
      m_vld = 1'b0;
      m_pay = '0;
    end else if (rdy) begin
      if (acc) begin
        m_vld = 1'b1;
        m_pay = '{rd: in_rd, op: in_op, pc: in_pc, imm: in_imm, pd: in_pd, rs1: o1, rs2: o2};
      end else if (out_ready) begin
        m_vld = 1'b0;
      end else if (m_vld && BYP && cm_en && cm_tag != 0) begin
        if (m_pay.rs1.tag == cm_tag) m_pay.rs1 = '{dt: cm_dt, tag: '0};
        if (m_pay.rs2.tag == cm_tag) m_pay.rs2 = '{dt: cm_dt, tag: '0};
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    rst = 0; rdy = 1; clr = 0; in_valid = 0; out_ready = 1;
    in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_op = 0; in_pc = 0; in_imm = 0; in_pd = 0;
    rn_en = 0; rn_reg = 0; rn_tag = 0; cm_en = 0; cm_reg = 0; cm_dt = 0; cm_tag = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; in_valid = 1; in_pc = 32'hFFFF_0000; rn_en = 1; rn_reg = 3; rn_tag = 5;
    tick();
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_tests++;
    if (dut_pay() !== '0) begin n_fail++; $display("FAIL reset_payload got=%h exp=0", dut_pay()); end
    idle();
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic_read();
    idle();
    in_valid = 1; in_rs1 = 5; in_rs2 = 6; in_rd = 7; in_op = 6'h2A;
    in_pc = 32'h0000_1000; in_imm = 32'h0000_0ABC; in_pd = 1;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_rs1_dt !== '0 || out_rs1_tag !== '0 || out_rs2_tag !== '0) begin
      n_fail++; $display("FAIL basic_operands got v=%b dt=%h tag=%h/%h exp v=1 dt=0 tag=0/0",
                         out_valid, out_rs1_dt, out_rs1_tag, out_rs2_tag);
    end
    n_tests++;
    if (out_pc !== 32'h1000 || out_rd !== 5'd7 || out_op !== 6'h2A || out_imm !== 32'hABC || out_pd !== 1'b1) begin
      n_fail++; $display("FAIL basic_passthru got pc=%h rd=%0d op=%h imm=%h pd=%b exp pc=1000 rd=7 op=2a imm=abc pd=1",
                         out_pc, out_rd, out_op, out_imm, out_pd);
    end
    idle();
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || out_pc !== 32'h1000) begin
      n_fail++; $display("FAIL basic_drain got v=%b pc=%h exp v=0 pc=1000", out_valid, out_pc);
    end
  endtask

  task automatic test_rename_commit();
    idle();
    in_valid = 1; in_rs1 = 5; rn_en = 1; rn_reg = 5; rn_tag = 3;
    tick();
    n_tests++;
    if (out_rs1_tag !== 4'd3) begin n_fail++; $display("FAIL rename_fwd got=%0d exp=3", out_rs1_tag); end
    idle();
    cm_en = 1; cm_reg = 5; cm_dt = 32'hDEAD; cm_tag = 3;
    tick();
    idle();
    in_valid = 1; in_rs1 = 5;
    tick();
    n_tests++;
    if (out_rs1_dt !== 32'hDEAD || out_rs1_tag !== 4'd0) begin
      n_fail++; $display("FAIL commit_read got dt=%h tag=%0d exp dt=dead tag=0", out_rs1_dt, out_rs1_tag);
    end
  endtask

  task automatic test_hold_wakeup();
    idle();
    rn_en = 1; rn_reg = 7; rn_tag = 7;
    tick();
    idle();
    in_valid = 1; in_rs2 = 7; out_ready = 0;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_rs2_tag !== 4'd7) begin
      n_fail++; $display("FAIL hold_load got v=%b tag=%0d exp v=1 tag=7", out_valid, out_rs2_tag);
    end
    idle();
    out_ready = 0; cm_en = 1; cm_reg = 7; cm_dt = 32'h1234; cm_tag = 7;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready got=%b exp=0", in_ready); end
    tick();
    n_tests++;
    if (BYP) begin
      if (out_rs2_dt !== 32'h1234 || out_rs2_tag !== 4'd0 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL hold_wakeup got dt=%h tag=%0d exp dt=1234 tag=0", out_rs2_dt, out_rs2_tag);
      end
    end else begin
      if (out_rs2_tag !== 4'd7 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL hold_nowake got tag=%0d exp=7", out_rs2_tag);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_rename_order();
    idle(); rn_en = 1; rn_reg = 8; rn_tag = 2; tick();
    idle(); rn_en = 1; rn_reg = 8; rn_tag = 4; tick();
    idle(); cm_en = 1; cm_reg = 8; cm_dt = 32'd9; cm_tag = 2; tick();
    idle(); in_valid = 1; in_rs1 = 8; tick();
    n_tests++;
    if (out_rs1_dt !== 32'd9 || out_rs1_tag !== 4'd4) begin
      n_fail++; $display("FAIL stale_commit got dt=%0d tag=%0d exp dt=9 tag=4", out_rs1_dt, out_rs1_tag);
    end
    idle(); rn_en = 1; rn_reg = 9; rn_tag = 6; tick();
    idle(); rn_en = 1; rn_reg = 9; rn_tag = 5; cm_en = 1; cm_reg = 9; cm_dt = 32'h55; cm_tag = 6; tick();
    idle(); in_valid = 1; in_rs2 = 9; tick();
    n_tests++;
    if (out_rs2_dt !== 32'h55 || out_rs2_tag !== 4'd5) begin
      n_fail++; $display("FAIL rename_beats_commit got dt=%h tag=%0d exp dt=55 tag=5", out_rs2_dt, out_rs2_tag);
    end
  endtask

  task automatic test_clr();
    for (int r = 1; r <= 3; r++) begin
      idle(); rn_en = 1; rn_reg = RW'(r); rn_tag = TAG_W'(r); tick();
    end
    idle(); in_valid = 1; in_rs1 = 1; in_rs2 = 2; out_ready = 0; tick();
    idle();
    out_ready = 0; clr = 1; cm_en = 1; cm_reg = 4; cm_dt = 32'h77; cm_tag = 0;
    in_valid = 1; in_rs1 = 3; in_pc = 32'hCAFE; rn_en = 1; rn_reg = 5; rn_tag = 9;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clr_in_ready got=%b exp=0", in_ready); end
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || dut_pay() !== '0) begin
      n_fail++; $display("FAIL clr_output got v=%b pay=%h exp v=0 pay=0", out_valid, dut_pay());
    end
    idle(); in_valid = 1; in_rs1 = 1; in_rs2 = 4; tick();
    n_tests++;
    if (out_rs1_tag !== 4'd0 || out_rs2_dt !== 32'h77 || out_rs2_tag !== 4'd0) begin
      n_fail++; $display("FAIL clr_commit got t1=%0d dt4=%h t4=%0d exp t1=0 dt4=77 t4=0",
                         out_rs1_tag, out_rs2_dt, out_rs2_tag);
    end
    idle(); in_valid = 1; in_rs1 = 3; in_rs2 = 5; tick();
    n_tests++;
    if (out_rs1_tag !== 4'd0 || out_rs2_tag !== 4'd0) begin
      n_fail++; $display("FAIL clr_tags got t3=%0d t5=%0d exp 0/0", out_rs1_tag, out_rs2_tag);
    end
  endtask

  task automatic test_x0_rdy();
    idle(); cm_en = 1; cm_reg = 0; cm_dt = 32'hFFFF; rn_en = 1; rn_reg = 0; rn_tag = 5; tick();
    idle(); in_valid = 1; tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_rs1_dt !== '0 || out_rs1_tag !== '0 || out_rs2_dt !== '0 || out_rs2_tag !== '0) begin
      n_fail++; $display("FAIL x0_read got v=%b dt=%h/%h tag=%0d/%0d exp v=1 all 0",
                         out_valid, out_rs1_dt, out_rs2_dt, out_rs1_tag, out_rs2_tag);
    end
    idle();
    rdy = 0; in_valid = 1; cm_en = 1; cm_reg = 10; cm_dt = 32'hABC; rn_en = 1; rn_reg = 11; rn_tag = 3;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rdy0_in_ready got=%b exp=0", in_ready); end
    tick();
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rdy0_freeze got v=%b exp=1", out_valid); end
    idle(); in_valid = 1; in_rs1 = 10; in_rs2 = 11; tick();
    n_tests++;
    if (out_rs1_dt !== 32'd0 || out_rs2_tag !== 4'd0) begin
      n_fail++; $display("FAIL rdy0_array got dt10=%h tag11=%0d exp 0/0", out_rs1_dt, out_rs2_tag);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      idle();
      rdy       = ($urandom_range(0, 7) != 0);
      clr       = ($urandom_range(0, 31) == 0);
      in_valid  = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      in_rs1    = RW'($urandom_range(0, 11));
      in_rs2    = RW'($urandom_range(0, 11));
      in_rd     = RW'($urandom);
      in_op     = OP_W'($urandom);
      in_pc     = $urandom;
      in_imm    = $urandom;
      in_pd     = $urandom_range(0, 1);
      rn_en     = ($urandom_range(0, 2) == 0);
      rn_reg    = RW'($urandom_range(0, 11));
      rn_tag    = TAG_W'($urandom);
      cm_en     = ($urandom_range(0, 2) == 0);
      cm_reg    = RW'($urandom_range(0, 11));
      cm_dt     = $urandom;
      case ($urandom_range(0, 2))
        0:       cm_tag = m_tag[cm_reg];
        1:       cm_tag = m_pay.rs2.tag;
        default: cm_tag = TAG_W'($urandom);
      endcase
      #1;
      n_tests++;
      if (in_ready !== m_ready()) begin
        n_fail++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", c, in_ready, m_ready());
      end
      tick();
      n_tests++;
      if (out_valid !== m_vld || dut_pay() !== m_pay) begin
        n_fail++; $display("FAIL rand_output cyc=%0d got v=%b pay=%h exp v=%b pay=%h",
                           c, out_valid, dut_pay(), m_vld, m_pay);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_rename_commit();
    test_hold_wakeup();
    test_rename_order();
    test_clr();
    test_x0_rdy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
